// File: rtl/z16_muldiv_unit.sv
// z16_muldiv_unit
// Iterative unsigned multiply/divide unit for the Z16 datapath. An operation
// is accepted from the register-file read ports when o_ready is high. The
// unit takes one shift-add (multiply) or restoring shift-subtract (divide)
// step per cycle. It then issues a single-cycle write-back toward the
// register-file write port.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      operation request, honoured only while o_ready=1
//   i_op         00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   i_rs1_data   multiplicand / dividend
//   i_rs2_data   multiplier / divisor
//   i_rd_addr    destination register
//   i_flush      abort any in-flight operation
//   o_ready      high while idle
//   o_busy       high while running or writing back
//   o_rd_wen     one-cycle write-back strobe (suppressed for rd=0)
//   o_rd_addr    destination of the last completed operation
//   o_rd_data    result of the last completed operation
module z16_muldiv_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ITER   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_flush,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_rd_wen,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  // Multiplicand for MUL*, divisor for DIV*.
  logic [DATA_W-1:0]   opb_q;
  // Upper half: partial product / partial remainder.
  // Lower half: remaining multiplier bits / dividend shifting into quotient.
  logic [2*DATA_W-1:0] acc_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                accept;
  logic                div_zero;
  logic                last_step;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_part;
  logic                div_ge;
  logic [DATA_W-1:0]   div_sub;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W-1:0]   step_result;

  assign accept    = (state_q == S_IDLE) && i_start && !i_flush;
  assign div_zero  = i_op[1] && (i_rs2_data == '0);
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(ITER - 1));

  // One iteration of the datapath, for both operation families.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
             + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Remainder shifted left with the next dividend bit brought in.
    // The result can need one extra bit.
    div_part = acc_q[2*DATA_W-1:DATA_W-1];
    div_ge   = (div_part >= {1'b0, opb_q});
    // Used only when div_ge holds. The true difference is below the divisor,
    // so keeping the low DATA_W bits loses nothing.
    div_sub  = div_part[DATA_W-1:0] - opb_q;
    if (!op_q[1]) begin
      acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end else if (div_ge) begin
      acc_step = {div_sub, acc_q[DATA_W-2:0], 1'b1};
    end else begin
      acc_step = {div_part[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end
    // MULHU/REMU take the upper half; MUL/DIVU take the lower half.
    step_result = op_q[0] ? acc_step[2*DATA_W-1:DATA_W]
                          : acc_step[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    // NOTE: registered state uses non-blocking assignments only. This way
    // every flop samples pre-edge values, whatever the order of the
    // processes.
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case statement. This
    // prevents any path from leaving a value unassigned and inferring a
    // latch.
    state_d  = state_q;
    o_ready  = 1'b0;
    o_busy   = 1'b0;
    o_rd_wen = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (accept) begin
          state_d = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (i_flush) begin
          state_d = S_IDLE;
        end else if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_busy   = 1'b1;
        // Writes to x0 are dropped. A flush or reset in this cycle also
        // kills the strobe.
        o_rd_wen = (rd_q != '0) && !i_flush && !i_rst;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      rd_q  <= i_rd_addr;
      cnt_q <= '0;
      opb_q <= i_op[1] ? i_rs2_data : i_rs1_data;
      acc_q <= {{DATA_W{1'b0}}, (i_op[1] ? i_rs1_data : i_rs2_data)};
      // Division by zero skips RUN. Its architectural result is
      // all-ones for DIVU and the dividend for REMU.
      if (div_zero) begin
        rd_addr_q <= i_rd_addr;
        rd_data_q <= i_op[0] ? i_rs1_data : {DATA_W{1'b1}};
      end
    end else if (state_q == S_RUN && !i_flush) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        rd_addr_q <= rd_q;
        rd_data_q <= step_result;
      end
    end
  end

  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_z16_muldiv_unit.sv
// tb_z16_muldiv_unit
// Self-checking bench for z16_muldiv_unit. The reference model is
// transaction-level: it computes each result with native arithmetic, applies a
// fixed latency, and tracks busy/write-back timing. A negedge compare process
// checks every DUT output against the model on every cycle. Directed tests add
// literal expectations, and a random phase follows them.
module tb_z16_muldiv_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [15:0] i_rs1_data;
  logic [15:0] i_rs2_data;
  logic [3:0]  i_rd_addr;
  logic        i_flush;
  logic        o_ready;
  logic        o_busy;
  logic        o_rd_wen;
  logic [3:0]  o_rd_addr;
  logic [15:0] o_rd_data;

  int checks   = 0;
  int failures = 0;

  z16_muldiv_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_rd_wen   (o_rd_wen),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'd0:    return p[15:0];
      2'd1:    return p[31:16];
      2'd2:    return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // Reference model state
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [15:0] m_res  = '0;
  logic [3:0]  m_rd   = '0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_addr = '0;
  logic        chk_en = 1'b0;
  int          wen_seen = 0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_data <= '0;
      m_addr <= '0;
    end else if (m_busy && i_flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_data <= m_res;
        m_addr <= m_rd;
      end
    end else if (i_start && !i_flush) begin
      m_busy <= 1'b1;
      m_res  <= ref_result(i_op, i_rs1_data, i_rs2_data);
      m_rd   <= i_rd_addr;
      if (i_op[1] && i_rs2_data == 16'h0) begin
        m_done <= 1'b1;
        m_data <= ref_result(i_op, i_rs1_data, i_rs2_data);
        m_addr <= i_rd_addr;
      end else begin
        m_left <= 16;
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("ready", 32'(o_ready), 32'(!m_busy));
      check("busy", 32'(o_busy), 32'(m_busy));
      check("wen", 32'(o_rd_wen),
            32'(m_done && (m_addr != 4'h0) && !i_flush && !i_rst));
      check("rd_addr", 32'(o_rd_addr), 32'(m_addr));
      check("rd_data", 32'(o_rd_data), 32'(m_data));
      if (o_rd_wen) wen_seen++;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] rd);
    i_start    = 1'b1;
    i_op       = op;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    step();
    // Scramble operands after the start edge. Captured values must not move.
    i_start    = 1'b0;
    i_op       = 2'($urandom);
    i_rs1_data = 16'($urandom);
    i_rs2_data = 16'($urandom);
    i_rd_addr  = 4'($urandom);
  endtask

  // Latency in cycles from the start edge to the first o_rd_wen (0 = never).
  task automatic wait_wen(output int lat, output int ready_hi);
    lat = 0;
    ready_hi = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clk);
      if (o_ready) ready_hi++;
      if (o_rd_wen) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clk);
      if (o_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [15:0] rand_val(input int zero_pct);
    int r;
    r = int'($urandom_range(99));
    if (r < zero_pct) return 16'h0;
    case ($urandom_range(5))
      0:       return 16'hFFFF;
      1:       return 16'($urandom_range(15));
      default: return 16'($urandom);
    endcase
  endfunction

  int lat;
  int rdy;
  int w0;

  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_op       = 2'd0;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_rd_addr  = '0;
    i_flush    = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_wen", 32'(o_rd_wen), 32'd0);
    check("rst_addr", 32'(o_rd_addr), 32'd0);
    check("rst_data", 32'(o_rd_data), 32'd0);
    step();
    i_rst = 1'b0;
    step();

    // MUL 0x1234 * 0x0010 -> 0x2340, 17-cycle latency, never ready meanwhile
    issue(2'd0, 16'h1234, 16'h0010, 4'd3);
    wait_wen(lat, rdy);
    check("mul_lat", 32'(lat), 32'd17);
    check("mul_ready_low", 32'(rdy), 32'd0);
    check("mul_data", 32'(o_rd_data), 32'h2340);
    check("mul_addr", 32'(o_rd_addr), 32'd3);
    step();

    issue(2'd1, 16'hFFFF, 16'hFFFF, 4'd5);
    wait_wen(lat, rdy);
    check("mulhu_data", 32'(o_rd_data), 32'hFFFE);
    step();
    issue(2'd0, 16'hFFFF, 16'hFFFF, 4'd5);
    wait_wen(lat, rdy);
    check("mul_ff_data", 32'(o_rd_data), 32'h0001);
    step();

    // Back-to-back divides: second start in the IDLE cycle right after DONE
    issue(2'd2, 16'd100, 16'd7, 4'd6);
    wait_wen(lat, rdy);
    check("divu_lat", 32'(lat), 32'd17);
    check("divu_data", 32'(o_rd_data), 32'h000E);
    step();
    issue(2'd3, 16'd100, 16'd7, 4'd7);
    wait_wen(lat, rdy);
    check("remu_lat", 32'(lat), 32'd17);
    check("remu_data", 32'(o_rd_data), 32'h0002);
    step();

    // Divide by zero
    issue(2'd2, 16'h1234, 16'h0000, 4'd8);
    wait_wen(lat, rdy);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_data", 32'(o_rd_data), 32'hFFFF);
    step();
    issue(2'd3, 16'h1234, 16'h0000, 4'd9);
    wait_wen(lat, rdy);
    check("rem0_lat", 32'(lat), 32'd1);
    check("rem0_data", 32'(o_rd_data), 32'h1234);
    step();

    // rd = 0: DONE reached (result registered) but no strobe
    w0 = wen_seen;
    issue(2'd0, 16'd3, 16'd4, 4'd0);
    wait_ready(lat);
    check("rd0_idle_lat", 32'(lat), 32'd18);
    check("rd0_no_wen", 32'(wen_seen - w0), 32'd0);
    check("rd0_data", 32'(o_rd_data), 32'h000C);
    step();

    // A start pulse while busy is ignored
    issue(2'd0, 16'd3, 16'd4, 4'd2);
    repeat (4) step();
    i_start    = 1'b1;
    i_op       = 2'd2;
    i_rs1_data = 16'd7;
    i_rs2_data = 16'd9;
    i_rd_addr  = 4'd11;
    step();
    i_start = 1'b0;
    wait_wen(lat, rdy);
    check("ign_lat", 32'(lat), 32'd12);
    check("ign_data", 32'(o_rd_data), 32'h000C);
    check("ign_addr", 32'(o_rd_addr), 32'd2);
    step();

    // Reset mid-RUN
    issue(2'd1, 16'hFFFF, 16'hFFFF, 4'd4);
    repeat (7) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_run_ready", 32'(o_ready), 32'd1);
    check("rst_run_data", 32'(o_rd_data), 32'd0);
    w0 = wen_seen;
    repeat (20) step();
    check("rst_run_no_wen", 32'(wen_seen - w0), 32'd0);

    // Flush mid-RUN keeps the previous result
    issue(2'd0, 16'h0011, 16'h0003, 4'd1);
    wait_wen(lat, rdy);
    check("pre_flush_data", 32'(o_rd_data), 32'h0033);
    step();
    issue(2'd0, 16'h0100, 16'h0100, 4'd4);
    repeat (7) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge i_clk);
    check("flush_ready", 32'(o_ready), 32'd1);
    check("flush_data", 32'(o_rd_data), 32'h0033);
    w0 = wen_seen;
    repeat (20) step();
    check("flush_no_wen", 32'(wen_seen - w0), 32'd0);

    // Flush together with start in IDLE: start ignored
    i_start = 1'b1;
    i_flush = 1'b1;
    i_op    = 2'd0;
    step();
    i_start = 1'b0;
    i_flush = 1'b0;
    @(negedge i_clk);
    check("flush_start_ready", 32'(o_ready), 32'd1);
    step();

    // Random phase
    for (int c = 0; c < 4000; c++) begin
      i_start    = ($urandom_range(2) != 0);
      i_op       = 2'($urandom);
      i_rs1_data = rand_val(10);
      i_rs2_data = rand_val(15);
      i_rd_addr  = 4'($urandom_range(15));
      i_flush    = ($urandom_range(49) == 0);
      i_rst      = ($urandom_range(399) == 0);
      step();
    end
    i_start = 1'b0;
    i_flush = 1'b0;
    i_rst   = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
